pp_filter_scheduler: RTL



---
 rtl/pp_filter_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pp_filter_scheduler.sv
// pp_filter_scheduler: frame sequencer and stack-SRAM arbiter between the LR check and the two hole-filling engines
// Optional feature macro: PP_DRAIN_TIMEOUT_EN (adds the DRAIN watchdog and the sticky timeout flag)
// Ports:
//   clk, rst, clken              clock, synchronous active-high reset, global clock enable
//   frame_start                  one-cycle frame start pulse, honoured only while idle
//   postprocessing_sel           1 = five-direction filler (engine 1), 0 = window filter (engine 0)
//   width, height                frame geometry, latched at frame start
//   valid_in                     LR-check pixel valid
//   en_e1, en_e0                 per-engine enables, only the frame owner can be enabled
//   sram_e1, sram_e0, sram_out   engine stack-SRAM control buses and the shared SRAM bus
//   disp_e1/valid_e1, disp_e0/valid_e0   engine outputs
//   disp_out, valid_out          owner engine output, zero while idle or done
//   busy, frame_done, timeout    status: running/draining, end-of-frame pulse, sticky drain timeout
module pp_filter_scheduler #(
   parameter int DWIDTH    = 16,
   parameter int AWIDTH    = 11,
   parameter int DRAIN_MAX = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clken,
   input  logic                  frame_start,
   input  logic                  postprocessing_sel,
   input  logic [10:0]           width,
   input  logic [10:0]           height,
   input  logic                  valid_in,
   output logic                  en_e1,
   output logic                  en_e0,
   input  logic [4+4*AWIDTH-1:0] sram_e1,
   input  logic [4+4*AWIDTH-1:0] sram_e0,
   output logic [4+4*AWIDTH-1:0] sram_out,
   input  logic [DWIDTH-1:0]     disp_e1,
   input  logic                  valid_e1,
   input  logic [DWIDTH-1:0]     disp_e0,
   input  logic                  valid_e0,
   output logic [DWIDTH-1:0]     disp_out,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  timeout
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
   state_t state, state_n;
   logic sel_q;
   logic [10:0] width_q, height_q, col, row;
   logic [21:0] out_cnt, out_cnt_n, total;
   logic active, start_acc, accept, col_wrap, last_px, out_inc, drained, tmo_hit;
   assign active    = (state == RUN) | (state == DRAIN);
   assign start_acc = clken & frame_start & (state == IDLE);
   assign accept    = valid_in & clken & (state == RUN);
   assign en_e1     = accept & sel_q;
   assign en_e0     = accept & ~sel_q;
   assign col_wrap  = col == width_q - 11'd1;
   assign last_px   = col_wrap & (row == height_q - 11'd1);
   assign sram_out  = active ? (sel_q ? sram_e1 : sram_e0) : '0;
   assign valid_out = active & (sel_q ? valid_e1 : valid_e0);
   assign disp_out  = active ? (sel_q ? disp_e1 : disp_e0) : '0;
   assign busy       = active;
   assign frame_done = state == DONE;
   assign total     = {11'd0, width_q} * {11'd0, height_q};
   assign out_inc   = valid_out & clken;
   // completion sees an output arriving in the same cycle
   assign out_cnt_n = out_cnt + {21'd0, out_inc};
   assign drained   = out_cnt_n >= total;
   always_comb begin
      state_n = state;
      if (clken)
         case (state)
            IDLE:    if (frame_start) state_n = (width == 11'd0 || height == 11'd0) ? DONE : RUN;
            RUN:     if (accept && last_px) state_n = DRAIN;
            DRAIN:   state_n = (drained || tmo_hit) ? DONE : DRAIN;
            default: state_n = IDLE;
         endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sel_q    <= 1'b0;
         width_q  <= '0;
         height_q <= '0;
         col      <= '0;
         row      <= '0;
         out_cnt  <= '0;
      end else begin
         state <= state_n;
         if (start_acc) begin
            sel_q    <= postprocessing_sel;
            width_q  <= width;
            height_q <= height;
            col      <= '0;
            row      <= '0;
            out_cnt  <= '0;
         end
         if (accept) begin
            col <= col_wrap ? 11'd0 : col + 11'd1;
            if (col_wrap) row <= row + 11'd1;
         end
         if (out_inc) out_cnt <= out_cnt_n;
      end
   end
`ifdef PP_DRAIN_TIMEOUT_EN
   localparam int DCW = $clog2(DRAIN_MAX) + 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);
   logic [DCW-1:0] drain_cnt;
   logic timeout_q;
   // the counter idles at zero so it always starts from zero on entry to DRAIN
   assign tmo_hit = clken & (state == DRAIN) & ~drained & (drain_cnt == DRAIN_LAST);
   assign timeout = timeout_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         drain_cnt <= '0;
         timeout_q <= 1'b0;
      end else if (clken) begin
         drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
         if (start_acc) timeout_q <= 1'b0;
         else if (tmo_hit) timeout_q <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif
endmodule
